key_4x4_emu: RTL



---
 rtl/key_pkg.sv | 22 ++
 rtl/key_bounce_lfsr.sv | 35 +++
 rtl/key_4x4_emu.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/key_pkg.sv
// Shared definitions for the 4x4 keypad emulator and the keypad scanner.
//   key_state_t : emulator press/release sequencing states
//   KEY_NONE    : row/column bus value meaning "no line active"
//   key_line_n  : active-low one-hot line pattern for a 2-bit row/column index
package key_pkg;

  typedef enum logic [2:0] {
    IDLE,
    P_BOUNCE,
    HOLD,
    R_BOUNCE,
    GAP
  } key_state_t;

  localparam logic [3:0] KEY_NONE = 4'b1111;

  // Line idx driven low, all others high (same table the scanner decodes).
  function automatic logic [3:0] key_line_n(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/key_bounce_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) supplying contact bounce noise.
// Advances only when en is high; the non-zero seed keeps it out of the
// all-zero lock-up state.
//   clk, rst : clock, asynchronous active-low reset (loads SEED)
//   en       : advance one step this cycle
//   bit_o    : current LFSR bit 0
module key_bounce_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic bit_o
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en) begin
      lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  always_comb bit_o = lfsr_q[0];

endmodule

// File: rtl/key_4x4_emu.sv
// 4x4 membrane keypad emulator: passive end of the scanner's row/column matrix.
// A press request closes the contact of key press_id (row id[3:2], column
// id[1:0]) through press bounce, hold, release bounce and an open gap, then
// pulses done.
// Optional feature macro KEY_EMU_BOUNCE_EN: when defined the contact chatters
// from an LFSR during both bounce windows; when undefined the contact switches
// cleanly at the start of each bounce window (same total cycle length).
//   clk, rst   : clock, asynchronous active-low reset
//   key_col_i  : scanner column drive, active-low
//   key_row_o  : row lines back to the scanner, active-low, 1111 = no contact
//   press_req  : start one press/release cycle (accepted in IDLE only)
//   press_id   : key id latched with an accepted press_req
//   busy       : cycle in progress
//   done       : one-cycle completion pulse
//   contact    : internal contact state
module key_4x4_emu
  import key_pkg::*;
#(
  parameter int unsigned CNT_W         = 24,
  parameter int unsigned BOUNCE_CYCLES = 100_000,
  parameter int unsigned BOUNCE_STEP   = 1_000,
  parameter int unsigned HOLD_CYCLES   = 2_000_000,
  parameter int unsigned GAP_CYCLES    = 2_000_000,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_col_i,
  output logic [3:0] key_row_o,
  input  logic       press_req,
  input  logic [3:0] press_id,
  output logic       busy,
  output logic       done,
  output logic       contact
);

  localparam logic [CNT_W-1:0] BOUNCE_LAST = CNT_W'(BOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);

  if (BOUNCE_STEP == 0 || (BOUNCE_CYCLES % BOUNCE_STEP) != 0) begin : g_bad_step
    $error("BOUNCE_STEP must be non-zero and divide BOUNCE_CYCLES");
  end
  if (LFSR_SEED == 16'h0000) begin : g_bad_seed
    $error("LFSR_SEED must be non-zero");
  end

  key_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       id_q, id_d;
  logic             contact_q, contact_d;
  logic             done_q, done_d;

`ifdef KEY_EMU_BOUNCE_EN
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(BOUNCE_STEP - 1);

  logic [CNT_W-1:0] step_q, step_d;
  logic             bouncing, step_tick, lfsr_bit;

  // Step counter restarts at every bounce window entry because it is held at
  // zero outside bounce states and BOUNCE_STEP divides BOUNCE_CYCLES.
  always_comb begin
    bouncing  = (state_q == P_BOUNCE) || (state_q == R_BOUNCE);
    step_tick = bouncing && (step_q == STEP_LAST);
    step_d    = (!bouncing || step_tick) ? '0 : step_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_q <= '0;
    end else begin
      step_q <= step_d;
    end
  end

  key_bounce_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .en    (step_tick),
    .bit_o (lfsr_bit)
  );
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    id_d      = id_q;
    contact_d = contact_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d     = '0;
        contact_d = 1'b0;
        // A request coinciding with the done pulse is dropped.
        if (press_req && !done_q) begin
          id_d    = press_id;
          state_d = P_BOUNCE;
`ifndef KEY_EMU_BOUNCE_EN
          contact_d = 1'b1;
`endif
        end
      end
      P_BOUNCE: begin
`ifdef KEY_EMU_BOUNCE_EN
        if (step_tick) contact_d = lfsr_bit;
`endif
        if (cnt_q == BOUNCE_LAST) begin
          contact_d = 1'b1;
          state_d   = HOLD;
          cnt_d     = '0;
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = R_BOUNCE;
          cnt_d   = '0;
`ifndef KEY_EMU_BOUNCE_EN
          contact_d = 1'b0;
`endif
        end
      end
      R_BOUNCE: begin
`ifdef KEY_EMU_BOUNCE_EN
        if (step_tick) contact_d = lfsr_bit;
`endif
        if (cnt_q == BOUNCE_LAST) begin
          contact_d = 1'b0;
          state_d   = GAP;
          cnt_d     = '0;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d   = IDLE;
        contact_d = 1'b0;
        cnt_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      id_q      <= '0;
      contact_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      id_q      <= id_d;
      contact_q <= contact_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    key_row_o = KEY_NONE;
    if (contact_q && !key_col_i[id_q[1:0]]) begin
      key_row_o = key_line_n(id_q[3:2]);
    end
    busy    = (state_q != IDLE);
    done    = done_q;
    contact = contact_q;
  end

endmodule
